// File: rtl/vga_timing_640_480.sv
// 640x480@60 Hz raster timing: pixel strobe, H/V phase FSMs, syncs, active-area indices.
// Optional `define VGA_TIMING_FRAME_CNT_EN adds a 16-bit wrapping frame counter output.
module vga_timing_640_480 #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        i_sclr,
    output logic        o_px_clk,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_haddr_enb,
    output logic        o_vaddr_enb,
    output logic        o_frame_en,
    output logic [9:0]  o_hidx,
    output logic [8:0]  o_vidx
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Phase boundaries: last count value of each phase.
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_TOT_END  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_TOT_END  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} hphase_t;
    typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} vphase_t;

    logic [PW-1:0] pcnt;
    logic [9:0]    hcnt;
    logic [9:0]    vcnt;
    hphase_t       hphase, hphase_nxt;
    vphase_t       vphase, vphase_nxt;
    logic          tick;
    logic          h_end;
    logic          v_adv;

    assign tick  = (pcnt == PW'(CLK_DIV - 1));
    assign h_end = (hcnt == H_TOT_END);
    assign v_adv = tick && h_end;

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            pcnt   <= '0;
            hcnt   <= '0;
            vcnt   <= '0;
            hphase <= HS_ACT;
            vphase <= VS_ACT;
        end else begin
            pcnt   <= tick ? '0 : pcnt + 1'b1;
            hphase <= hphase_nxt;
            vphase <= vphase_nxt;
            if (tick)
                hcnt <= h_end ? '0 : hcnt + 10'd1;
            if (v_adv)
                vcnt <= (vcnt == V_TOT_END) ? '0 : vcnt + 10'd1;
        end
    end

    always_comb begin
        hphase_nxt = hphase;
        if (tick) begin
            case (hphase)
                HS_ACT:  if (hcnt == H_ACT_END)  hphase_nxt = HS_FP;
                HS_FP:   if (hcnt == H_FP_END)   hphase_nxt = HS_SYNC;
                HS_SYNC: if (hcnt == H_SYNC_END) hphase_nxt = HS_BP;
                HS_BP:   if (hcnt == H_TOT_END)  hphase_nxt = HS_ACT;
                default: hphase_nxt = HS_ACT;
            endcase
        end
    end

    // Vertical phase only moves on the last pixel of a line.
    always_comb begin
        vphase_nxt = vphase;
        if (v_adv) begin
            case (vphase)
                VS_ACT:  if (vcnt == V_ACT_END)  vphase_nxt = VS_FP;
                VS_FP:   if (vcnt == V_FP_END)   vphase_nxt = VS_SYNC;
                VS_SYNC: if (vcnt == V_SYNC_END) vphase_nxt = VS_BP;
                VS_BP:   if (vcnt == V_TOT_END)  vphase_nxt = VS_ACT;
                default: vphase_nxt = VS_ACT;
            endcase
        end
    end

    assign o_px_clk    = tick;
    assign o_haddr_enb = (hphase == HS_ACT);
    assign o_vaddr_enb = (vphase == VS_ACT);
    assign o_hsync     = (hphase != HS_SYNC);
    assign o_vsync     = (vphase != VS_SYNC);
    assign o_hidx      = o_haddr_enb ? hcnt : '0;
    assign o_vidx      = o_vaddr_enb ? vcnt[8:0] : '0;
    assign o_frame_en  = v_adv && (vcnt == V_TOT_END);

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (i_sclr)
            frame_cnt <= '0;
        else if (o_frame_en)
            frame_cnt <= frame_cnt + 16'd1;
    end

    assign o_frame_cnt = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_640_480.sv
// Directed bench for vga_timing_640_480: default geometry, a CLK_DIV=2 instance,
// and a tiny-geometry instance so whole frames fit in a short run.
module tb_vga_timing_640_480;

    logic clk = 1'b0;
    logic sclr = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default instance
    logic a_px, a_hs, a_vs, a_he, a_ve, a_fe;
    logic [9:0] a_hidx;
    logic [8:0] a_vidx;
    // CLK_DIV=2, default geometry
    logic d_px, d_hs, d_vs, d_he, d_ve, d_fe;
    logic [9:0] d_hidx;
    logic [8:0] d_vidx;
    // CLK_DIV=2, H 8/2/3/2 (15), V 6/2/2/2 (12): line 30 clk, frame 360 clk
    logic s_px, s_hs, s_vs, s_he, s_ve, s_fe;
    logic [9:0] s_hidx;
    logic [8:0] s_vidx;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] a_fc, d_fc, s_fc;
`endif

    vga_timing_640_480 u_a (
        .clk(clk), .i_sclr(sclr), .o_px_clk(a_px), .o_hsync(a_hs), .o_vsync(a_vs),
        .o_haddr_enb(a_he), .o_vaddr_enb(a_ve), .o_frame_en(a_fe),
        .o_hidx(a_hidx), .o_vidx(a_vidx)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .o_frame_cnt(a_fc)
`endif
    );

    vga_timing_640_480 #(.CLK_DIV(2)) u_d (
        .clk(clk), .i_sclr(sclr), .o_px_clk(d_px), .o_hsync(d_hs), .o_vsync(d_vs),
        .o_haddr_enb(d_he), .o_vaddr_enb(d_ve), .o_frame_en(d_fe),
        .o_hidx(d_hidx), .o_vidx(d_vidx)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .o_frame_cnt(d_fc)
`endif
    );

    vga_timing_640_480 #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_s (
        .clk(clk), .i_sclr(sclr), .o_px_clk(s_px), .o_hsync(s_hs), .o_vsync(s_vs),
        .o_haddr_enb(s_he), .o_vaddr_enb(s_ve), .o_frame_en(s_fe),
        .o_hidx(s_hidx), .o_vidx(s_vidx)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .o_frame_cnt(s_fc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int a_px_n, a_hs_low, a_he_hi, a_fe_n, a_rise0, a_rise1, a_hsf0, a_hsf1;
    int d_rise0, d_rise1;
    int s_fe_n, s_fe_first, s_vs_low, s_ve_fall, s_vs_fall, s_fe_bad;
    logic a_he_p, a_hs_p, d_he_p, s_ve_p, s_vs_p;

    initial begin
        repeat (3) step();
        check("rst_px",    a_px,   0);
        check("rst_hsync", a_hs,   1);
        check("rst_vsync", a_vs,   1);
        check("rst_henb",  a_he,   1);
        check("rst_venb",  a_ve,   1);
        check("rst_hidx",  a_hidx, 0);
        check("rst_vidx",  a_vidx, 0);
        check("rst_frame", a_fe,   0);
        sclr = 1'b0;

        // ---- free run from release: cycle 0 is the current sample ----
        a_px_n = 0; a_hs_low = 0; a_he_hi = 0; a_fe_n = 0;
        a_rise0 = -1; a_rise1 = -1; a_hsf0 = -1; a_hsf1 = -1;
        d_rise0 = -1; d_rise1 = -1;
        s_fe_n = 0; s_fe_first = -1; s_vs_low = 0; s_ve_fall = -1; s_vs_fall = -1; s_fe_bad = 0;
        a_he_p = a_he; a_hs_p = a_hs; d_he_p = d_he; s_ve_p = s_ve; s_vs_p = s_vs;
        for (int c = 0; c <= 6400; c++) begin
            if (c == 2) check("px_c2", a_px, 0);
            if (c == 3) check("px_c3", a_px, 1);
            if (c == 7) check("px_c7", a_px, 1);
            if (c == 1) check("d_px_c1", d_px, 1);
            if (c == 2559) begin check("hidx_639", a_hidx, 639); check("henb_639", a_he, 1); end
            if (c == 2560) begin check("hidx_640", a_hidx, 0);   check("henb_640", a_he, 0); end
            if (c == 2623) check("hs_655", a_hs, 1);
            if (c == 2624) check("hs_656", a_hs, 0);
            if (c == 3007) check("hs_751", a_hs, 0);
            if (c == 3008) check("hs_752", a_hs, 1);
            if (c == 3200) begin
                check("henb_l1", a_he, 1);
                check("hidx_l1", a_hidx, 0);
                check("vidx_l1", a_vidx, 1);
                check("venb_l1", a_ve, 1);
                check("l0_px_pulses", a_px_n, 800);
                check("l0_hs_low",    a_hs_low, 384);
                check("l0_henb_hi",   a_he_hi, 2560);
            end
            if (c == 3204) check("hidx_1", a_hidx, 1);
            if (c == 4) check("s_hidx_2", s_hidx, 2);
            if (c == 150) check("s_vidx_5", s_vidx, 5);
            if (c == 360) check("s_vs_low_frame", s_vs_low, 60);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (c == 1080) check("s_frame_cnt_3", s_fc, 3);
`endif
            if (c < 3200) begin
                if (a_px) a_px_n++;
                if (!a_hs) a_hs_low++;
                if (a_he) a_he_hi++;
            end
            if (c < 360 && !s_vs) s_vs_low++;
            if (a_fe) a_fe_n++;
            if (a_he && !a_he_p) begin if (a_rise0 < 0) a_rise0 = c; else if (a_rise1 < 0) a_rise1 = c; end
            if (!a_hs && a_hs_p) begin if (a_hsf0 < 0) a_hsf0 = c; else if (a_hsf1 < 0) a_hsf1 = c; end
            if (d_he && !d_he_p) begin if (d_rise0 < 0) d_rise0 = c; else if (d_rise1 < 0) d_rise1 = c; end
            if (!s_ve && s_ve_p && s_ve_fall < 0) s_ve_fall = c;
            if (!s_vs && s_vs_p && s_vs_fall < 0) s_vs_fall = c;
            if (s_fe && c <= 1080) begin
                s_fe_n++;
                if (s_fe_first < 0) s_fe_first = c;
                if (s_he || s_ve || !s_px) s_fe_bad++;
            end
            a_he_p = a_he; a_hs_p = a_hs; d_he_p = d_he; s_ve_p = s_ve; s_vs_p = s_vs;
            step();
        end
        check("a_line_rise0",   a_rise0, 3200);
        check("a_line_len",     a_rise1 - a_rise0, 3200);
        check("a_hs_fall0",     a_hsf0, 2624);
        check("a_hs_period",    a_hsf1 - a_hsf0, 3200);
        check("a_no_frame_en",  a_fe_n, 0);
        check("d_line_rise0",   d_rise0, 1600);
        check("d_line_len",     d_rise1 - d_rise0, 1600);
        check("s_frame_en_n",   s_fe_n, 3);
        check("s_frame_first",  s_fe_first, 359);
        check("s_frame_en_ctx", s_fe_bad, 0);
        check("s_venb_fall",    s_ve_fall, 180);
        check("s_vsync_fall",   s_vs_fall, 240);

        // ---- now at cycle 6401 (line 2, h=0); move to h=300 then reset mid-line ----
        repeat (1199) step();
        check("pre_hidx_300", a_hidx, 300);
        check("pre_vidx_2",   a_vidx, 2);
        sclr = 1'b1;
        step();
        check("mid_hidx",  a_hidx, 0);
        check("mid_vidx",  a_vidx, 0);
        check("mid_px",    a_px,   0);
        check("mid_hsync", a_hs,   1);
        check("mid_vsync", a_vs,   1);
        check("mid_henb",  a_he,   1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("mid_frame_cnt", s_fc, 0);
`endif
        sclr = 1'b0;

        a_hsf0 = -1; a_hsf1 = -1; a_hs_p = a_hs;
        for (int c = 0; c <= 5824; c++) begin
            if (c == 3) check("post_px_c3", a_px, 1);
            if (!a_hs && a_hs_p) begin if (a_hsf0 < 0) a_hsf0 = c; else if (a_hsf1 < 0) a_hsf1 = c; end
            a_hs_p = a_hs;
            step();
        end
        check("post_hs_fall0",  a_hsf0, 2624);
        check("post_line_len",  a_hsf1 - a_hsf0, 3200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_640_480.md
# vga_timing_640_480

Raster timing generator for 640x480@60 Hz VGA, directly upstream of `gen_640_480`. It divides the system clock into a single-cycle pixel strobe and runs horizontal and vertical phase state machines with position counters. From these it drives sync pulses, active-area enables, pixel/line indices and a once-per-frame update strobe. All outputs sit in the system clock domain.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; legal range ≥2 (100 MHz → 25 MHz).
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal phase lengths, in pixels.
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical phase lengths, in lines.
- `clk` in 1: system clock. One clock; all state is updated on its rising edge.
- `i_sclr` in 1: synchronous, active-high reset.
- `o_px_clk` out 1: pixel strobe, high for one `clk` every `CLK_DIV` cycles.
- `o_hsync` out 1: horizontal sync, active low.
- `o_vsync` out 1: vertical sync, active low.
- `o_haddr_enb` out 1: horizontal active area.
- `o_vaddr_enb` out 1: vertical active area.
- `o_frame_en` out 1: one-`clk` pulse at the end of each frame.
- `o_hidx` out 10: pixel column 0..639; 0 outside the active area.
- `o_vidx` out 9: line 0..479; 0 outside the active area.

## Operation
- Prescaler `pcnt`, width ceil(log2 `CLK_DIV`):
  - counts 0..`CLK_DIV`-1 and wraps to 0.
  - tick = (`pcnt`==`CLK_DIV`-1).
  - `o_px_clk` = tick.
- Horizontal counter `hcnt` (10 bit, 0..799) advances on tick and wraps 799→0.
- Horizontal FSM `hphase` ∈ {H_ACT, H_FP, H_SYNC, H_BP}:
  - transitions on tick.
  - H_ACT→H_FP when `hcnt`==639.
  - H_FP→H_SYNC at 655.
  - H_SYNC→H_BP at 751.
  - H_BP→H_ACT at 799.
- Vertical counter `vcnt` (10 bit internal, 0..524) advances on tick when `hcnt`==799; it wraps 524→0.
- Vertical FSM `vphase` ∈ {V_ACT, V_FP, V_SYNC, V_BP}:
  - advances under the same condition as `vcnt`.
  - boundaries at `vcnt` 479, 489, 491, 524.
- Boundaries are derived from the parameters: sums minus 1.
- Output decode from registered state:
  - `o_haddr_enb` = (`hphase`==H_ACT).
  - `o_vaddr_enb` = (`vphase`==V_ACT).
  - `o_hsync` = (`hphase`!=H_SYNC).
  - `o_vsync` = (`vphase`!=V_SYNC).
  - `o_hidx` = `o_haddr_enb` ? `hcnt` : 0.
  - `o_vidx` = `o_vaddr_enb` ? `vcnt`[8:0] : 0.
- `o_frame_en` = tick & `hcnt`==799 & `vcnt`==524. It fires exactly once per frame, inside vertical blanking.
- `i_sclr` has priority over everything, including mid-line or mid-frame. It forces `pcnt`=0, `hcnt`=0, `vcnt`=0, `hphase`=H_ACT, `vphase`=V_ACT.
- Reset output values:
  - `o_px_clk`=0, `o_frame_en`=0.
  - `o_hsync`=1, `o_vsync`=1.
  - `o_haddr_enb`=1, `o_vaddr_enb`=1.
  - `o_hidx`=0, `o_vidx`=0.
- Illegal phase encodings recover to H_ACT or V_ACT on the next tick.

## Timing
- The first tick occurs `CLK_DIV` cycles after `i_sclr` deasserts, i.e. on cycle `CLK_DIV`-1 counting from 0.
- Position and phase state change on the `clk` edge that ends a tick cycle. Outputs are stable for `CLK_DIV` cycles between changes.
- Downstream logic samples pixel state while `o_px_clk`=1. The sampled value is the pixel currently displayed.
- Line period = 800×`CLK_DIV` clk (3200 by default).
- Frame period = 420 000×`CLK_DIV` clk (1 680 000 by default).
- `o_hsync` low for 96 ticks, beginning on the tick-edge after `hcnt`=655.
- `o_vsync` low for 2 lines (1600 ticks).
- `o_frame_en` coincides with `o_px_clk`. The next edge returns the counters to (0,0).

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - adds output `o_frame_cnt` (16 bit).
  - reset value 0.
  - increments on each `o_frame_en` and wraps 65535→0.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset then free-run, default params:
  - `o_px_clk` pulses every 4 clk.
  - first pulse on cycle 3 after release.
- One line:
  - `o_haddr_enb` high for 640 ticks.
  - `o_hidx` runs 0..639, then reads 0.
  - `o_hsync` low for exactly 96 ticks, starting 16 ticks after `o_haddr_enb` falls.
  - line length 3200 clk.
- Full frame:
  - `o_vaddr_enb` high for 480 lines.
  - `o_vsync` low for 2 lines, starting 10 lines after active ends.
  - `o_frame_en` exactly one pulse per 1 680 000 clk, with `o_haddr_enb`=`o_vaddr_enb`=0 at that cycle.
- `i_sclr` asserted mid-line (`hcnt`=300, `vcnt`=200):
  - next cycle `o_hidx`=0, `o_vidx`=0, `o_px_clk`=0, syncs high.
  - the following line is a full 3200 clk.
- `CLK_DIV`=2: line = 1600 clk, frame = 840 000 clk.
- With `VGA_TIMING_FRAME_CNT_EN`: after 3 frames `o_frame_cnt`=3; `i_sclr` returns it to 0.
